// File: rtl/mem_arb_pkg.sv
// Shared state encoding, op codes and default bus widths for the two-port memory arbiter.
package mem_arb_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH = 8;
  localparam int unsigned DEFAULT_ADDR_WIDTH = 4;

  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

endpackage

// File: rtl/mem_arb_rr.sv
// Two-way round-robin winner select; i_prio names the requester that wins a tie.
module mem_arb_rr (
  input  logic i_req0,
  input  logic i_req1,
  input  logic i_prio,
  output logic o_valid_c,
  output logic o_grant_c
);

  assign o_valid_c = i_req0 | i_req1;

  always_comb begin
    o_grant_c = 1'b0;
    if (i_req0 && i_req1) begin
      o_grant_c = i_prio;
    end else if (i_req1) begin
      o_grant_c = 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates two requesters onto one single-port memory; every access takes a fixed
// IDLE -> ISSUE -> WAIT -> RESP sequence with all outputs registered.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  op0,
  input  logic                  op1,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] data_in0,
  input  logic [DATA_WIDTH-1:0] data_in1,
  output logic                  ack0,
  output logic                  ack1,
  output logic [DATA_WIDTH-1:0] rdata0,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic                  busy,
  output logic                  mem_en,
  output logic                  mem_op,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data_in,
  input  logic [DATA_WIDTH-1:0] mem_data_out
);

  state_t                r_state;
  state_t                w_state_nxt;

  logic                  r_prio;
  logic                  r_grant;
  logic                  r_op;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_rdata0;
  logic [DATA_WIDTH-1:0] r_rdata1;
  logic                  r_mem_en;
  logic                  r_busy;
  logic                  r_ack0;
  logic                  r_ack1;

  logic                  w_valid;
  logic                  w_grant;
  logic                  w_load_cmd;
  logic                  w_load_rd;
  logic                  w_mem_en_nxt;
  logic                  w_busy_nxt;
  logic                  w_ack0_nxt;
  logic                  w_ack1_nxt;

  mem_arb_rr u_rr (
    .i_req0    (req0),
    .i_req1    (req1),
    .i_prio    (r_prio),
    .o_valid_c (w_valid),
    .o_grant_c (w_grant)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state: only IDLE looks at the requests
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_valid) w_state_nxt = ISSUE;
      ISSUE:   w_state_nxt = WAIT;
      WAIT:    w_state_nxt = RESP;
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Next values of the registered outputs, decoded from the coming state
  always_comb begin
    w_load_cmd   = (r_state == IDLE) && w_valid;
    w_load_rd    = (r_state == WAIT) && (r_op == OP_READ);
    w_mem_en_nxt = (w_state_nxt == ISSUE);
    w_busy_nxt   = (w_state_nxt != IDLE);
    w_ack0_nxt   = (r_state == WAIT) && !r_grant;
    w_ack1_nxt   = (r_state == WAIT) && r_grant;
  end

  // Command latch, round-robin pointer, read-data and strobe registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_prio   <= 1'b0;
      r_grant  <= 1'b0;
      r_op     <= OP_READ;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata0 <= '0;
      r_rdata1 <= '0;
      r_mem_en <= 1'b0;
      r_busy   <= 1'b0;
      r_ack0   <= 1'b0;
      r_ack1   <= 1'b0;
    end else begin
      r_mem_en <= w_mem_en_nxt;
      r_busy   <= w_busy_nxt;
      r_ack0   <= w_ack0_nxt;
      r_ack1   <= w_ack1_nxt;
      if (w_load_cmd) begin
        r_grant <= w_grant;
        r_prio  <= ~w_grant;
        r_op    <= w_grant ? op1 : op0;
        r_addr  <= w_grant ? addr1 : addr0;
        r_wdata <= w_grant ? data_in1 : data_in0;
      end
      if (w_load_rd) begin
        if (r_grant) begin
          r_rdata1 <= mem_data_out;
        end else begin
          r_rdata0 <= mem_data_out;
        end
      end
    end
  end

  // The latched command doubles as the memory-side bus, so it holds outside ISSUE
  assign mem_en      = r_mem_en;
  assign mem_op      = r_op;
  assign mem_addr    = r_addr;
  assign mem_data_in = r_wdata;
  assign busy        = r_busy;
  assign ack0        = r_ack0;
  assign ack1        = r_ack1;
  assign rdata0      = r_rdata0;
  assign rdata1      = r_rdata1;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed access table, hand-written corner
// sequences, then random traffic against a transaction-timing reference model.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int unsigned DW = 8;
  localparam int unsigned AW = 4;

  logic          clk;
  logic          reset;
  logic          req0, req1, op0, op1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] data_in0, data_in1;
  logic          ack0, ack1, busy, mem_en, mem_op;
  logic [DW-1:0] rdata0, rdata1, mem_data_in, mem_data_out;
  logic [AW-1:0] mem_addr;

  logic [DW-1:0] mem [16];

  int n_chk  = 0;
  int n_pass = 0;

  mem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk          (clk),
    .reset        (reset),
    .req0         (req0),
    .req1         (req1),
    .op0          (op0),
    .op1          (op1),
    .addr0        (addr0),
    .addr1        (addr1),
    .data_in0     (data_in0),
    .data_in1     (data_in1),
    .ack0         (ack0),
    .ack1         (ack1),
    .rdata0       (rdata0),
    .rdata1       (rdata1),
    .busy         (busy),
    .mem_en       (mem_en),
    .mem_op       (mem_op),
    .mem_addr     (mem_addr),
    .mem_data_in  (mem_data_in),
    .mem_data_out (mem_data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural memory: read data is valid the cycle after the strobe
  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 8'(16 * i + 5);
    mem_data_out = '0;
    forever begin
      @(posedge clk);
      if (mem_en) begin
        if (mem_op == OP_WRITE) mem[mem_addr] <= mem_data_in;
        else mem_data_out <= mem[mem_addr];
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic          r0, r1, o0, o1;
    logic [AW-1:0] a0, a1;
    logic [DW-1:0] d0, d1;
    logic          g;
    logic [DW-1:0] e0, e1;
  } vec_t;

  function automatic vec_t mk(input logic r0, input logic r1, input logic o0, input logic o1,
                              input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                              input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                              input logic g, input logic [DW-1:0] e0, input logic [DW-1:0] e1);
    vec_t v;
    v.r0 = r0; v.r1 = r1; v.o0 = o0; v.o1 = o1;
    v.a0 = a0; v.a1 = a1; v.d0 = d0; v.d1 = d1;
    v.g  = g;  v.e0 = e0; v.e1 = e1;
    return v;
  endfunction

  // One complete access starting in an IDLE cycle; checks strobe, ack timing and read data
  task automatic run_entry(input vec_t v);
    req0 = v.r0; req1 = v.r1; op0 = v.o0; op1 = v.o1;
    addr0 = v.a0; addr1 = v.a1; data_in0 = v.d0; data_in1 = v.d1;
    step();
    chk("issue_mem_en", 32'(mem_en), 32'(1'b1));
    chk("issue_busy", 32'(busy), 32'(1'b1));
    chk("issue_cmd", 32'({mem_op, mem_addr, mem_data_in}),
        v.g ? 32'({v.o1, v.a1, v.d1}) : 32'({v.o0, v.a0, v.d0}));
    step();
    chk("wait_mem_en", 32'(mem_en), 32'(1'b0));
    chk("wait_ack", 32'({ack1, ack0}), 32'(2'b00));
    step();
    chk("resp_ack", 32'({ack1, ack0}), v.g ? 32'(2'b10) : 32'(2'b01));
    chk("resp_rdata0", 32'(rdata0), 32'(v.e0));
    chk("resp_rdata1", 32'(rdata1), 32'(v.e1));
    req0 = 1'b0; req1 = 1'b0;
    step();
    chk("idle_busy", 32'(busy), 32'(1'b0));
    chk("idle_ack", 32'({ack1, ack0}), 32'(2'b00));
  endtask

  // Reference model state: an access granted at cycle t_g strobes at t_g, acks at t_g+2
  int            cyc;
  int            t_g;
  logic          m_prio, m_g, m_op;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data, m_rd0, m_rd1;
  logic [DW-1:0] mem_m [16];
  logic          p_req  [2];
  logic          p_op   [2];
  logic [AW-1:0] p_addr [2];
  logic [DW-1:0] p_data [2];

  task automatic model_reset();
    t_g = cyc - 10;
    m_prio = 1'b0; m_g = 1'b0; m_op = 1'b0;
    m_addr = '0; m_data = '0; m_rd0 = '0; m_rd1 = '0;
  endtask

  task automatic model_edge();
    logic w;
    cyc++;
    if (!reset) begin
      if ((cyc - 1 - t_g) >= 3 && (req0 || req1)) begin
        w = (req0 && req1) ? m_prio : req1;
        t_g = cyc; m_g = w; m_prio = ~w;
        m_op = w ? op1 : op0;
        m_addr = w ? addr1 : addr0;
        m_data = w ? data_in1 : data_in0;
      end
      if (cyc - t_g == 1 && m_op == OP_WRITE) mem_m[m_addr] = m_data;
      if (cyc - t_g == 2 && m_op == OP_READ) begin
        if (m_g) m_rd1 = mem_m[m_addr];
        else m_rd0 = mem_m[m_addr];
      end
    end
  endtask

  vec_t tbl [10];

  initial begin
    reset = 1'b1;
    req0 = 1'b0; req1 = 1'b0; op0 = OP_READ; op1 = OP_READ;
    addr0 = '0; addr1 = '0; data_in0 = '0; data_in1 = '0;
    cyc = 0; t_g = -10;

    // Reset held 30 ns: everything quiet during and after
    #22;
    chk("rst_outputs", 32'({mem_en, busy, ack1, ack0}), 32'(4'b0000));
    chk("rst_rdata", 32'({rdata1, rdata0}), 32'(16'h0000));
    chk("rst_mem_cmd", 32'({mem_op, mem_addr, mem_data_in}), 32'(0));
    #8;
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("post_rst_quiet", 32'({mem_en, busy, ack1, ack0}), 32'(4'b0000));
    end

    // Directed access table, in order; expectations carry memory and pointer history
    tbl[0] = mk(1, 0, OP_WRITE, OP_READ,  4'h3, 4'h0, 8'hA5, 8'h00, 0, 8'h00, 8'h00);
    tbl[1] = mk(1, 0, OP_READ,  OP_READ,  4'h3, 4'h0, 8'h00, 8'h00, 0, 8'hA5, 8'h00);
    tbl[2] = mk(0, 1, OP_READ,  OP_READ,  4'h0, 4'hF, 8'h00, 8'h00, 1, 8'hA5, 8'hF5);
    tbl[3] = mk(1, 1, OP_READ,  OP_READ,  4'h0, 4'h1, 8'h00, 8'h00, 0, 8'h05, 8'hF5);
    tbl[4] = mk(1, 1, OP_WRITE, OP_WRITE, 4'h5, 4'h6, 8'h11, 8'h22, 1, 8'h05, 8'hF5);
    tbl[5] = mk(1, 1, OP_READ,  OP_READ,  4'h6, 4'h5, 8'h00, 8'h00, 0, 8'h22, 8'hF5);
    tbl[6] = mk(0, 1, OP_READ,  OP_READ,  4'h0, 4'h6, 8'h00, 8'h00, 1, 8'h22, 8'h22);
    tbl[7] = mk(1, 0, OP_WRITE, OP_READ,  4'hF, 4'h0, 8'h5A, 8'h00, 0, 8'h22, 8'h22);
    tbl[8] = mk(0, 1, OP_READ,  OP_READ,  4'h0, 4'hF, 8'h00, 8'h00, 1, 8'h22, 8'h5A);
    tbl[9] = mk(1, 1, OP_READ,  OP_WRITE, 4'h3, 4'h0, 8'h00, 8'h77, 0, 8'hA5, 8'h5A);
    for (int i = 0; i < 10; i++) run_entry(tbl[i]);

    // Both requesters held high from reset: grants alternate 0,1,0,1
    reset = 1'b1;
    #1;
    chk("rst_clears_rdata", 32'({rdata1, rdata0}), 32'(16'h0000));
    step();
    reset = 1'b0;
    req0 = 1'b1; op0 = OP_WRITE; addr0 = 4'h1; data_in0 = 8'h81;
    req1 = 1'b1; op1 = OP_WRITE; addr1 = 4'h2; data_in1 = 8'h82;
    for (int k = 1; k <= 16; k++) begin
      step();
      chk("rr_ack", 32'({ack1, ack0}),
          (k % 4 == 3) ? (((k / 4) % 2 == 1) ? 32'(2'b10) : 32'(2'b01)) : 32'(2'b00));
    end
    req0 = 1'b0; req1 = 1'b0;
    step();
    chk("rr_idle_busy", 32'(busy), 32'(1'b0));

    // Reset in WAIT of a read: drop the access, clear rdata, pointer back to requester 0
    run_entry(mk(1, 0, OP_WRITE, OP_READ, 4'h9, 4'h0, 8'h3C, 8'h00, 0, 8'h00, 8'h00));
    run_entry(mk(0, 1, OP_READ,  OP_READ, 4'h0, 4'h9, 8'h00, 8'h00, 1, 8'h00, 8'h3C));
    run_entry(mk(1, 0, OP_READ,  OP_READ, 4'h2, 4'h0, 8'h00, 8'h00, 0, 8'h82, 8'h3C));
    req0 = 1'b1; op0 = OP_READ; addr0 = 4'h9; data_in0 = 8'h00;
    step();
    step();
    chk("wait_busy", 32'(busy), 32'(1'b1));
    reset = 1'b1;
    #1;
    chk("rst_wait_state", 32'({mem_en, busy, ack1, ack0}), 32'(4'b0000));
    chk("rst_wait_rdata", 32'({rdata1, rdata0}), 32'(16'h0000));
    req0 = 1'b0;
    step();
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("rst_no_ack", 32'({mem_en, busy, ack1, ack0}), 32'(4'b0000));
    end
    run_entry(mk(1, 1, OP_READ, OP_READ, 4'h9, 4'h1, 8'h00, 8'h00, 0, 8'h3C, 8'h00));

    // Request withdrawn during ISSUE still completes, then the arbiter idles
    req0 = 1'b1; op0 = OP_READ; addr0 = 4'h2;
    step();
    chk("wd_mem_en", 32'(mem_en), 32'(1'b1));
    req0 = 1'b0;
    step();
    step();
    chk("wd_ack", 32'({ack1, ack0}), 32'(2'b01));
    chk("wd_rdata0", 32'(rdata0), 32'(8'h82));
    step();
    step();
    chk("wd_idle", 32'({mem_en, busy, ack1, ack0}), 32'(4'b0000));

    // Random traffic against the reference model
    reset = 1'b1;
    model_reset();
    step();
    cyc++;
    reset = 1'b0;
    for (int i = 0; i < 16; i++) mem_m[i] = mem[i];
    for (int i = 0; i < 2; i++) begin
      p_req[i] = 1'b0; p_op[i] = 1'b0; p_addr[i] = '0; p_data[i] = '0;
    end
    for (int c = 0; c < 1500; c++) begin
      int age;
      age = cyc - t_g;
      if (reset) begin
        reset = 1'b0;
      end else if ($urandom_range(0, 149) == 0) begin
        reset = 1'b1;
        model_reset();
        for (int i = 0; i < 2; i++) p_req[i] = 1'b0;
      end
      if (!reset) begin
        for (int i = 0; i < 2; i++) begin
          if (age == 2 && m_g == 1'(i)) p_req[i] = 1'b0;
          else if (p_req[i] && age == 0 && m_g == 1'(i) && $urandom_range(0, 5) == 0) p_req[i] = 1'b0;
          if (!p_req[i] && !(age >= 0 && age <= 1 && m_g == 1'(i)) && $urandom_range(0, 2) == 0) begin
            p_req[i]  = 1'b1;
            p_op[i]   = 1'($urandom_range(0, 1));
            p_addr[i] = AW'($urandom_range(0, 15));
            p_data[i] = DW'($urandom);
          end
        end
      end
      req0 = p_req[0]; op0 = p_op[0]; addr0 = p_addr[0]; data_in0 = p_data[0];
      req1 = p_req[1]; op1 = p_op[1]; addr1 = p_addr[1]; data_in1 = p_data[1];
      @(posedge clk);
      model_edge();
      #1;
      age = cyc - t_g;
      chk("rnd_mem_en", 32'(mem_en), 32'(age == 0));
      chk("rnd_busy", 32'(busy), 32'(age >= 0 && age <= 2));
      chk("rnd_ack", 32'({ack1, ack0}), (age == 2) ? (m_g ? 32'(2'b10) : 32'(2'b01)) : 32'(2'b00));
      chk("rnd_mem_cmd", 32'({mem_op, mem_addr, mem_data_in}), 32'({m_op, m_addr, m_data}));
      chk("rnd_rdata", 32'({rdata1, rdata0}), 32'({m_rd1, m_rd0}));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 8: width of every data bus.
REQ-002 Parameter ADDR_WIDTH, default 4: width of every address bus.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 req0 / req1  input  1  access request from requester 0 / 1; held high until the matching ack.
REQ-006 op0 / op1  input  1  operation code: 1 = write, 0 = read.
REQ-007 addr0 / addr1  input  ADDR_WIDTH  access address.
REQ-008 data_in0 / data_in1  input  DATA_WIDTH  write data.
REQ-009 ack0 / ack1  output  1  one-cycle completion pulse.
REQ-010 rdata0 / rdata1  output  DATA_WIDTH  read result, registered.
REQ-011 busy  output  1  high whenever state is not IDLE.
REQ-012 mem_en  output  1  memory access strobe.
REQ-013 mem_op  output  1  op forwarded to memory: 1 = write, 0 = read.
REQ-014 mem_addr  output  ADDR_WIDTH  address forwarded to memory.
REQ-015 mem_data_in  output  DATA_WIDTH  write data forwarded to memory.
REQ-016 mem_data_out  input  DATA_WIDTH  memory read data, valid the cycle after a read strobe.

Function
REQ-017 The FSM SHALL have states IDLE, ISSUE, WAIT, RESP, with transitions IDLE->ISSUE on any request, ISSUE->WAIT, WAIT->RESP and RESP->IDLE unconditionally.
REQ-018 Requests SHALL be sampled only in IDLE; at the IDLE->ISSUE edge the arbiter SHALL latch the grant index, op, addr and data_in of the winner.
REQ-019 If exactly one of req0/req1 is high, that requester SHALL win.
REQ-020 If both are high, the requester not granted last SHALL win (round-robin pointer); after reset, requester 0 SHALL have priority.
REQ-021 The round-robin pointer SHALL update only on a grant.
REQ-022 In ISSUE, mem_en SHALL be 1 and mem_op/mem_addr/mem_data_in SHALL carry the latched command; in every other state mem_en SHALL be 0 and the other memory outputs SHALL hold their values.
REQ-023 In WAIT, for a read, mem_data_out SHALL be loaded into the granted requester's rdata register at the WAIT->RESP edge; the other rdata register and writes SHALL leave rdata unchanged.
REQ-024 In RESP, ack of the granted requester SHALL be 1 for exactly one cycle; the other ack SHALL stay 0.
REQ-025 Latency SHALL be fixed: request seen in IDLE at cycle N -> ack at cycle N+3; maximum throughput is one access per 4 cycles.
REQ-026 A request withdrawn after grant SHALL NOT abort the access; the access completes and acks normally.
REQ-027 A req still high in the IDLE cycle after RESP SHALL be treated as a new request.
REQ-028 Address and data SHALL pass through unmodified with no width conversion.

Reset
REQ-029 Asserting reset in any state SHALL immediately force IDLE and clear the following to 0: mem_en, mem_op, mem_addr, mem_data_in, ack0, ack1, rdata0, rdata1, busy.
REQ-030 Asserting reset SHALL set the round-robin pointer to favour requester 0.
REQ-031 An access interrupted by reset SHALL be dropped with no ack, and no memory strobe SHALL issue after reset asserts.

Structure
REQ-032 Package mem_arb_pkg SHALL hold the state enum (IDLE, ISSUE, WAIT, RESP), constants OP_READ=0 and OP_WRITE=1, and the default widths.
REQ-033 A combinational sub-module mem_arb_rr SHALL compute the winner from req0, req1 and the pointer; the FSM and registers SHALL stay in mem_arbiter.

Verification
REQ-034 Reset held 30 ns then released -> all outputs 0, busy=0, no mem_en pulse.
REQ-035 req0 write addr=3 data=0xA5, then req0 read addr=3 -> mem_en for one cycle each, ack0 at N+3 each time, rdata0=0xA5.
REQ-036 req0 and req1 both high from reset -> grants in order 0,1,0,1; ack0 and ack1 never high together.
REQ-037 req1 alone, read addr=0xF -> rdata1 = memory contents, rdata0 unchanged, ack1 at N+3.
REQ-038 Reset asserted during WAIT of a read -> IDLE next sample, no ack, rdata cleared to 0, pointer favours requester 0.
REQ-039 req0 dropped in ISSUE -> access completes, ack0 pulses in RESP, next IDLE idles.
